// File: rtl/lb_2_cube_pkg.sv
// lb_2_cube shared types: one-hot FSM states and
// LB read / skid buffer depth constants.
package lb_2_cube_pkg;

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    RUN   = 4'b0010,
    DRAIN = 4'b0100,
    DONE  = 4'b1000
  } state_t;

  localparam int LB_RD_LATENCY = 1;
  localparam int SKID_DEPTH    = 2;

endpackage

// File: rtl/lb_skid_fifo.sv
// Two-entry skid FIFO between LB read data and the cube stream.
// Simultaneous push and pop leave occupancy unchanged.
module lb_skid_fifo
  import lb_2_cube_pkg::*;
#(
  parameter int DATA_WID = 128
) (
  input  logic                clock,
  input  logic                rst_n,
  input  logic                push,
  input  logic                pop,
  input  logic [DATA_WID-1:0] wdata,
  output logic [DATA_WID-1:0] head,
  output logic                empty,
  output logic [1:0]          occupancy
);

  logic [DATA_WID-1:0] mem [SKID_DEPTH];
  logic                wp;
  logic                rp;
  logic [1:0]          cnt;
  logic                do_push;
  logic                do_pop;

  assign do_pop  = pop && (cnt != 2'd0);
  assign do_push = push &&
                   ((cnt != 2'(SKID_DEPTH)) || do_pop);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= 2'd0;
      for (int i = 0; i < SKID_DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= wdata;
        wp      <= ~wp;
      end
      if (do_pop)
        rp <= ~rp;
      cnt <= cnt + 2'(do_push) - 2'(do_pop);
    end
  end

  assign head      = mem[rp];
  assign empty     = (cnt == 2'd0);
  assign occupancy = cnt;

endmodule

// File: rtl/lb_2_cube.sv
// Streams one LB tile to the cube over valid/ready with a 2-entry skid.
// Optional LB2CUBE_STALL_CNT_EN adds a saturating stall_cnt output.
module lb_2_cube
  import lb_2_cube_pkg::*;
#(
  parameter int ADDR_WID = 10,
  parameter int DATA_WID = 128,
  parameter int CNT_WID  = 11
) (
  input  logic                clock,
  input  logic                rst_n,
  input  logic                trans_start,
  output logic                trans_end,
  input  logic [ADDR_WID-1:0] start_addr,
  input  logic [CNT_WID-1:0]  num_words,
  output logic                rd_en,
  output logic [ADDR_WID-1:0] rd_addr,
  input  logic [DATA_WID-1:0] data_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_WID-1:0] out_data,
  output logic                out_last
`ifdef LB2CUBE_STALL_CNT_EN
  ,
  output logic [15:0]         stall_cnt
`endif
);

  state_t                   state;
  state_t                   nstate;
  logic [ADDR_WID-1:0]      base_addr;
  logic [CNT_WID-1:0]       nwords;
  logic [CNT_WID-1:0]       issue_cnt;
  logic [CNT_WID-1:0]       acc_cnt;
  logic [LB_RD_LATENCY-1:0] rd_pipe;
  logic [1:0]               occ;
  logic                     empty;
  logic                     issue;
  logic                     pop;
  logic                     start;
  logic                     credit_ok;

  assign pop   = out_valid && out_ready;
  assign start = (state == IDLE) && trans_start;

  // Held words plus reads in flight, net of this cycle's pop.
  assign credit_ok = (int'(occ) + $countones(rd_pipe)
                      - int'(pop)) < SKID_DEPTH;

  always_comb begin
    nstate = state;
    issue  = 1'b0;
    unique case (state)
      IDLE: begin
        if (trans_start)
          nstate = (num_words == '0) ? DONE : RUN;
      end
      RUN: begin
        issue = credit_ok;
        if (issue && (issue_cnt == nwords - CNT_WID'(1)))
          nstate = DRAIN;
      end
      DRAIN: begin
        if (pop && out_last)
          nstate = DONE;
      end
      DONE: nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      base_addr <= '0;
      nwords    <= '0;
      issue_cnt <= '0;
      acc_cnt   <= '0;
      rd_pipe   <= '0;
    end else begin
      state   <= nstate;
      rd_pipe <= LB_RD_LATENCY'({rd_pipe, issue});
      if (start) begin
        base_addr <= start_addr;
        nwords    <= num_words;
        issue_cnt <= '0;
        acc_cnt   <= '0;
      end else begin
        if (issue)
          issue_cnt <= issue_cnt + CNT_WID'(1);
        if (pop)
          acc_cnt <= acc_cnt + CNT_WID'(1);
      end
    end
  end

  lb_skid_fifo #(
    .DATA_WID (DATA_WID)
  ) u_fifo (
    .clock     (clock),
    .rst_n     (rst_n),
    .push      (rd_pipe[LB_RD_LATENCY-1]),
    .pop       (pop),
    .wdata     (data_in),
    .head      (out_data),
    .empty     (empty),
    .occupancy (occ)
  );

  assign rd_en     = issue;
  assign rd_addr   = base_addr + ADDR_WID'(issue_cnt);
  assign out_valid = !empty;
  assign out_last  = out_valid &&
                     (acc_cnt == nwords - CNT_WID'(1));
  assign trans_end = (state == IDLE) || (state == DONE);

`ifdef LB2CUBE_STALL_CNT_EN
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (start)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_lb_2_cube.sv
// Scoreboard bench for lb_2_cube: LB memory model, random stimulus,
// decoupled monitor comparing addresses and stream words.
module tb_lb_2_cube;

  logic         clock = 1'b0;
  logic         rst_n;
  logic         trans_start;
  logic         trans_end;
  logic [9:0]   start_addr;
  logic [10:0]  num_words;
  logic         rd_en;
  logic [9:0]   rd_addr;
  logic [127:0] data_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         out_last;
`ifdef LB2CUBE_STALL_CNT_EN
  logic [15:0]  stall_cnt;
`endif

  typedef struct {
    logic [127:0] d;
    logic         l;
  } exp_t;

  exp_t         exp_q[$];
  logic [9:0]   addr_q[$];
  logic [127:0] lb_mem [1024];
  int           compared = 0;
  int           mismatched = 0;
  int           mode = 0;
  int           cyc = 0;
  logic         pat [4];
  logic         prev_stall = 1'b0;
  logic [127:0] prev_data = '0;

  lb_2_cube dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .trans_start (trans_start),
    .trans_end   (trans_end),
    .start_addr  (start_addr),
    .num_words   (num_words),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .data_in     (data_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last)
`ifdef LB2CUBE_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clock = ~clock;

  // Synchronous LB: data one cycle after rd_en.
  always @(posedge clock)
    if (rd_en) data_in <= lb_mem[rd_addr];

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  task automatic fail_now(input string nm);
    compared++;
    mismatched++;
    $display("FAIL %s: got event required none", nm);
  endtask

  // Ready driver: changes just after posedge, stable at negedge.
  always @(posedge clock) begin
    #1;
    cyc++;
    case (mode)
      0: out_ready = 1'b1;
      1: out_ready = pat[cyc % 4];
      2: out_ready = 1'($urandom_range(0, 1));
      default: ;
    endcase
  end

  always @(negedge clock) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 128'(out_valid), 128'(1));
        chk("stall_data", out_data, prev_data);
      end
      if (rd_en) begin
        if (addr_q.size() == 0) fail_now("extra_read");
        else chk("rd_addr", 128'(rd_addr),
                 128'(addr_q.pop_front()));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("extra_word");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_last", 128'(out_last), 128'(e.l));
        end
      end
      if (rd_en) begin
        compared++;
        if (exp_q.size() - addr_q.size() > 2) begin
          mismatched++;
          $display("FAIL read_ahead: got %0d required <=2",
                   exp_q.size() - addr_q.size());
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic start_xfer(input logic [9:0] a,
                            input logic [10:0] n);
    @(negedge clock);
    for (int i = 0; i < int'(n); i++) begin
      exp_t e;
      logic [9:0] ad;
      ad  = a + 10'(i);
      e.d = lb_mem[ad];
      e.l = (i == int'(n) - 1);
      addr_q.push_back(ad);
      exp_q.push_back(e);
    end
    start_addr  = a;
    num_words   = n;
    trans_start = 1'b1;
    @(posedge clock);
    #1;
    trans_start = 1'b0;
    start_addr  = 10'($urandom);
    num_words   = 11'($urandom);
    if (n != 0) chk("trans_end_busy", 128'(trans_end), 128'(0));
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge clock);
      t++;
    end
    if (t >= 3000) fail_now("timeout");
    for (int k = 0; k < 2; k++) begin
      @(posedge clock);
      #1;
      if (trans_end) break;
    end
    chk("trans_end_done", 128'(trans_end), 128'(1));
    chk("reads_left", 128'(addr_q.size()), 128'(0));
    repeat (2) @(posedge clock);
  endtask

  initial begin
    int k;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    for (int i = 0; i < 1024; i++)
      lb_mem[i] = {$urandom, $urandom, $urandom, $urandom};
    rst_n       = 1'b0;
    trans_start = 1'b0;
    start_addr  = '0;
    num_words   = '0;
    out_ready   = 1'b1;
    data_in     = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_trans_end", 128'(trans_end), 128'(1));
    chk("rst_rd_en", 128'(rd_en), 128'(0));
    chk("rst_rd_addr", 128'(rd_addr), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_last", 128'(out_last), 128'(0));
    @(negedge clock);
    rst_n = 1'b1;
    repeat (2) @(posedge clock);

    // basic streaming with latency check
    mode = 0;
    start_xfer(10'd0, 11'd16);
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (!out_valid && k < 10);
    chk("first_valid_edge", 128'(k - 1), 128'(2));
    wait_done();

    // backpressure 1,0,0,1
    mode = 1;
    start_xfer(10'd300, 11'd8);
    wait_done();

    // address wrap
    mode = 0;
    start_xfer(10'd1020, 11'd8);
    wait_done();

    // zero length
    start_xfer(10'd50, 11'd0);
    chk("zero_trans_end", 128'(trans_end), 128'(1));
    repeat (4) begin
      @(negedge clock);
      chk("zero_quiet", 128'({rd_en, out_valid}), 128'(0));
    end

    // random transfers under random backpressure
    mode = 2;
    repeat (6) begin
      start_xfer(10'($urandom), 11'($urandom_range(1, 40)));
      wait_done();
    end

    // start pulse while busy is ignored
    start_xfer(10'd100, 11'd30);
    repeat (6) @(posedge clock);
    @(negedge clock);
    trans_start = 1'b1;
    start_addr  = 10'd5;
    num_words   = 11'd3;
    @(posedge clock);
    #1;
    trans_start = 1'b0;
    wait_done();

    // asynchronous reset mid-transfer
    mode = 0;
    start_xfer(10'd200, 11'd64);
    repeat (10) @(posedge clock);
    #2;
    rst_n = 1'b0;
    addr_q.delete();
    exp_q.delete();
    #1;
    chk("mid_rst_rd_en", 128'(rd_en), 128'(0));
    chk("mid_rst_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_trans_end", 128'(trans_end), 128'(1));
    @(posedge clock);
    @(negedge clock);
    rst_n = 1'b1;
    repeat (2) @(posedge clock);
    start_xfer(10'd7, 11'd4);
    wait_done();

`ifdef LB2CUBE_STALL_CNT_EN
    mode = 3;
    out_ready = 1'b0;
    start_xfer(10'd400, 11'd4);
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (!out_valid && k < 10);
    repeat (5) @(posedge clock);
    #1;
    out_ready = 1'b1;
    wait_done();
    chk("stall_cnt", 128'(stall_cnt), 128'(5));
    mode = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
